reg_shift_univ: RTL and testbench

- Parametrised successor of the team's 16-bit load register.
- Adds multi-cycle shift and rotate operations by a programmable amount, sequenced by a small FSM with a start/busy/done handshake, plus a serial-in/serial-out bit.
- Used as a general-purpose datapath register where a barrel shifter is too costly.
- Shifts one bit per cycle.

---
 rtl/reg_shift_univ.sv | 101 ++++++++++
 tb/tb_reg_shift_univ.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_shift_univ.sv
// General-purpose datapath register with parallel load and multi-cycle shift/rotate.
// A small FSM steps the register one bit per cycle and reports completion through busy/done.
module reg_shift_univ #(
  parameter  int WIDTH = 16,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [SHW-1:0]   amt,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             sout
);

  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_SRL = 3'b010;
  localparam logic [2:0] OP_SRA = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b100;
  localparam logic [2:0] OP_ROR = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t           state;
  logic [2:0]       op_lat;
  logic [SHW-1:0]   count;
  logic             shift_op;

  // One single-bit step; result is {bit shifted out, next register value}.
  function automatic logic [WIDTH:0] step(
    input logic [2:0]       f_op,
    input logic [WIDTH-1:0] f_q,
    input logic             f_sin,
    input logic             f_sout
  );
    logic [WIDTH:0] r;
    case (f_op)
      OP_SLL:  r = {f_q[WIDTH-1], f_q[WIDTH-2:0], f_sin};
      OP_SRL:  r = {f_q[0], f_sin, f_q[WIDTH-1:1]};
      OP_SRA:  r = {f_q[0], f_q[WIDTH-1], f_q[WIDTH-1:1]};
      OP_ROL:  r = {f_q[WIDTH-1], f_q[WIDTH-2:0], f_q[WIDTH-1]};
      OP_ROR:  r = {f_q[0], f_q[0], f_q[WIDTH-1:1]};
      default: r = {f_sout, f_q};
    endcase
    return r;
  endfunction

  assign shift_op = (op >= OP_SLL) && (op <= OP_ROR);
  assign busy     = (state == SHIFT);
  assign done     = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      q      <= '0;
      sout   <= 1'b0;
      op_lat <= 3'b000;
      count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ld) begin
            q <= d;
          end else if (start) begin
            // Zero-length or NOP requests still produce a completion pulse.
            if (shift_op && (amt != '0)) begin
              op_lat <= op;
              count  <= amt;
              state  <= SHIFT;
            end else begin
              state <= DONE;
            end
          end
        end
        SHIFT: begin
          {sout, q} <= step(op_lat, q, sin, sout);
          count     <= count - SHW'(1);
          if (count == SHW'(1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_shift_univ.sv
// Directed bench for reg_shift_univ: load, shifts, rotates, priority/ignore rules and
// asynchronous reset abort, each compared against hand-computed values.
module tb_reg_shift_univ;

  localparam int WIDTH = 16;
  localparam int SHW   = $clog2(WIDTH);

  logic             clk;
  logic             rst;
  logic             ld;
  logic [WIDTH-1:0] d;
  logic             start;
  logic [2:0]       op;
  logic [SHW-1:0]   amt;
  logic             sin;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
  logic             sout;

  int checks   = 0;
  int failures = 0;

  reg_shift_univ #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .ld    (ld),
    .d     (d),
    .start (start),
    .op    (op),
    .amt   (amt),
    .sin   (sin),
    .q     (q),
    .busy  (busy),
    .done  (done),
    .sout  (sout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [WIDTH-1:0] v);
    ld = 1'b1;
    d  = v;
    @(negedge clk);
    ld = 1'b0;
  endtask

  task automatic start_op(input logic [2:0] o, input logic [SHW-1:0] a, input logic s);
    start = 1'b1;
    op    = o;
    amt   = a;
    sin   = s;
    @(negedge clk);
    start = 1'b0;
    op    = 3'b000;
    amt   = '0;
  endtask

  // Watches a bounded window; index 1 is the cycle right after the start edge.
  task automatic watch(input int first, output int nbusy, output int ndone, output int done_at);
    nbusy   = 0;
    ndone   = 0;
    done_at = -1;
    for (int k = first; k < first + 24; k++) begin
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        if (done_at < 0) done_at = k;
      end
      @(negedge clk);
    end
  endtask

  int nb, nd, da;

  initial begin
    rst = 1'b0; ld = 1'b0; d = '0; start = 1'b0; op = 3'b000; amt = '0; sin = 1'b0;

    // Reset and load
    repeat (2) @(negedge clk);
    chk("rst_q", q, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sout", sout, 0);
    rst = 1'b1;
    @(negedge clk);
    load(16'hA5C3);
    chk("load_q", q, 16'hA5C3);

    // SLL by 4
    load(16'h1234);
    start_op(3'b001, 4, 1'b0);
    watch(1, nb, nd, da);
    chk("sll_busy_cycles", nb, 4);
    chk("sll_done_count", nd, 1);
    chk("sll_done_at", da, 5);
    chk("sll_q", q, 16'h2340);
    chk("sll_sout", sout, 1);

    // SRA by 3
    load(16'h8010);
    start_op(3'b011, 3, 1'b0);
    watch(1, nb, nd, da);
    chk("sra_done_at", da, 4);
    chk("sra_q", q, 16'hF002);
    chk("sra_sout", sout, 0);

    // SRL by 2 filling with sin=1
    load(16'h0F00);
    start_op(3'b010, 2, 1'b1);
    watch(1, nb, nd, da);
    chk("srl_q", q, 16'hC3C0);
    chk("srl_sout", sout, 0);
    sin = 1'b0;

    // Rotates
    load(16'h0001);
    start_op(3'b101, 1, 1'b0);
    watch(1, nb, nd, da);
    chk("ror_busy_cycles", nb, 1);
    chk("ror_q", q, 16'h8000);
    chk("ror_sout", sout, 1);
    load(16'h8001);
    start_op(3'b100, 15, 1'b0);
    watch(1, nb, nd, da);
    chk("rol_busy_cycles", nb, 15);
    chk("rol_done_at", da, 16);
    chk("rol_q", q, 16'hC000);
    chk("rol_sout", sout, 0);

    // ld wins over start in the same IDLE cycle
    ld = 1'b1; d = 16'h5A5A; start = 1'b1; op = 3'b001; amt = 3;
    @(negedge clk);
    ld = 1'b0; start = 1'b0; op = 3'b000; amt = '0;
    chk("ldstart_q", q, 16'h5A5A);
    watch(1, nb, nd, da);
    chk("ldstart_busy", nb, 0);
    chk("ldstart_done", nd, 0);
    chk("ldstart_q_hold", q, 16'h5A5A);

    // ld pulsed while busy is ignored
    load(16'h00F0);
    start_op(3'b010, 4, 1'b0);
    chk("ldbusy_busy", busy, 1);
    ld = 1'b1; d = 16'hFFFF;
    @(negedge clk);
    ld = 1'b0;
    watch(2, nb, nd, da);
    chk("ldbusy_busy_rest", nb, 3);
    chk("ldbusy_done_at", da, 5);
    chk("ldbusy_q", q, 16'h000F);

    // amt=0 and NOP complete immediately without touching q
    load(16'h00FF);
    start_op(3'b001, 0, 1'b1);
    watch(1, nb, nd, da);
    chk("amt0_busy", nb, 0);
    chk("amt0_done_at", da, 1);
    chk("amt0_q", q, 16'h00FF);
    start_op(3'b110, 5, 1'b1);
    watch(1, nb, nd, da);
    chk("nop_done_at", da, 1);
    chk("nop_busy", nb, 0);
    chk("nop_q", q, 16'h00FF);
    sin = 1'b0;

    // Asynchronous reset mid-operation
    load(16'hFFFF);
    start_op(3'b001, 8, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("abort_busy_before", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("abort_q", q, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    @(negedge clk);
    rst = 1'b1;
    watch(1, nb, nd, da);
    chk("abort_no_done", nd, 0);
    chk("abort_no_busy", nb, 0);
    load(16'h0001);
    start_op(3'b001, 1, 1'b1);
    watch(1, nb, nd, da);
    chk("post_reset_q", q, 16'h0003);
    chk("post_reset_sout", sout, 0);
    chk("post_reset_done", nd, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
